// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: run-control state encoding
// and fetch-width defaults.
package mips_pkg;

  localparam int unsigned STATE_W             = 3;
  localparam int unsigned INSTR_BYTES_DEFAULT = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } run_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register with synchronous reset to a fixed vector and a
// load enable.
module pc_reg
  import mips_pkg::*;
#(
  parameter int unsigned           PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] d,
  output logic [PC_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VECTOR;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// IF-stage PC controller: next-PC selection, hazard stalls and the debug
// run-control FSM that drains the pipeline after a HALT instruction.
module pc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned         INSTR_BYTES  = INSTR_BYTES_DEFAULT,
  parameter int unsigned         DRAIN_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_halt_req,
  input  logic                i_pc_write,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_jump,
  input  logic [PC_WIDTH-1:0] i_jump_target,
  input  logic                i_halt_instr,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [PC_WIDTH-1:0] o_pc_seq,
  output logic                o_enable,
  output logic                o_fetch_valid,
  output logic [STATE_W-1:0]  o_state,
  output logic                o_halted,
  output logic                o_step_done
);

  localparam int unsigned         CNT_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INSTR_BYTES - 1);

  run_state_e          state;
  run_state_e          state_nxt;
  logic [CNT_W-1:0]    drain_cnt;
  logic [CNT_W-1:0]    drain_cnt_nxt;
  logic                halted_q;
  logic                step_done_q;
  logic                exec_c;
  logic                halt_acc_c;
  logic                pc_load_c;
  logic [PC_WIDTH-1:0] pc_nxt_c;

  // RUN and STEP are the only states that fetch and may advance the PC
  assign exec_c     = (state == ST_RUN) || (state == ST_STEP);
  assign halt_acc_c = exec_c && i_halt_instr && i_pc_write;
  assign pc_load_c  = o_enable && i_pc_write && exec_c && !halt_acc_c;

  always_comb begin
    pc_nxt_c = o_pc_seq;
    if (i_branch_taken) begin
      pc_nxt_c = i_branch_target & ALIGN_MASK;
    end else if (i_jump) begin
      pc_nxt_c = i_jump_target & ALIGN_MASK;
    end
  end

  pc_reg #(
    .PC_WIDTH     (PC_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (pc_load_c),
    .d     (pc_nxt_c),
    .q     (o_pc)
  );

  assign o_pc_seq = o_pc + PC_INC;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      drain_cnt   <= '0;
      halted_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      drain_cnt   <= drain_cnt_nxt;
      halted_q    <= (state_nxt == ST_HALTED);
      step_done_q <= (state == ST_STEP) && (state_nxt == ST_IDLE);
    end
  end

  // Run-control next state; HALT beats debug requests, DRAIN counts down to HALTED
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (i_run) begin
          state_nxt = ST_RUN;
        end else if (i_step) begin
          state_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_acc_c) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
        end else if (i_halt_req) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_acc_c) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == CNT_W'(1)) begin
          state_nxt     = ST_HALTED;
          drain_cnt_nxt = '0;
        end else begin
          drain_cnt_nxt = drain_cnt - CNT_W'(1);
        end
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
      end
      default: begin
        state_nxt     = ST_IDLE;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  assign o_enable      = exec_c || (state == ST_DRAIN);
  assign o_fetch_valid = exec_c;
  assign o_state       = state;
  assign o_halted      = halted_q;
  assign o_step_done   = step_done_q;

endmodule
